// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: request unit FSM state encoding and timeout counter width.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } ru_state_t;

  localparam int TMO_W = 8;

endpackage

// File: rtl/ru_arb_if.sv
// Bundle of the request-unit arbiter controller/cache signals; modport ru is the arbiter's view.
interface ru_arb_if #(
  parameter int NPORT = 2
);
  localparam int SW = $clog2(NPORT);

  logic             ctr_iREN;
  logic [NPORT-1:0] ctr_dREN;
  logic [NPORT-1:0] ctr_dWEN;
  logic             ihit;
  logic             dhit;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic [SW-1:0]    dsel;
  logic [NPORT-1:0] dgrant;
  logic             dtmo;

  modport ru (
    input  ctr_iREN, ctr_dREN, ctr_dWEN, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, dsel, dgrant, dtmo
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting port at or after i_ptr, wrapping at NPORT.
module rr_arbiter #(
  parameter int NPORT = 2,
  localparam int SW = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [SW-1:0]    i_ptr,
  output logic [NPORT-1:0] o_grant,
  output logic [SW-1:0]    o_idx,
  output logic             o_valid
);

  logic [SW:0]   w_sum;
  logic [SW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int i = 0; i < NPORT; i++) begin
      // Wrap explicitly so non-power-of-two port counts stay in range.
      w_sum = {1'b0, i_ptr} + (SW+1)'(i);
      if (w_sum >= (SW+1)'(NPORT)) w_sum = w_sum - (SW+1)'(NPORT);
      w_j = w_sum[SW-1:0];
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/request_unit_arb.sv
// Request unit arbiter: shares one data cache port among NPORT requesters, with
// round-robin fairness, abandonment on timeout or flush, and optional i-fetch yield.
module request_unit_arb
  import cpu_types_pkg::*;
#(
  parameter int NPORT   = 2,
  parameter int TMO_MAX = 255,
  parameter int IYIELD  = 1,
  localparam int SW = $clog2(NPORT)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ctr_iREN,
  input  logic [NPORT-1:0] ctr_dREN,
  input  logic [NPORT-1:0] ctr_dWEN,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [SW-1:0]    dsel,
  output logic [NPORT-1:0] dgrant,
  output logic             dtmo,
  output logic [1:0]       dbg_state
);

  // Handshake: a port holds ctr_dREN/ctr_dWEN until it sees its dgrant bit (one
  // cycle, same cycle as dhit) or dtmo; dropping the request early withdraws it.

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  ru_state_t        r_state;
  ru_state_t        w_next;
  logic [TMO_W-1:0] r_cnt;
  logic [SW-1:0]    r_last;
  logic [SW-1:0]    r_dsel;
  logic [SW-1:0]    w_ptr;
  logic [NPORT-1:0] w_req;
  logic [NPORT-1:0] w_arb_grant;
  logic [SW-1:0]    w_arb_idx;
  logic             w_arb_valid;
  logic             w_hit;
  logic             w_tmo;
  logic             w_unused_ihit;

  assign w_unused_ihit = ihit;
  assign w_req = ctr_dREN | ctr_dWEN;
  assign w_ptr = (r_last == SW'(NPORT - 1)) ? '0 : r_last + SW'(1);

  rr_arbiter #(.NPORT(NPORT)) u_rr (
    .i_req   (w_req),
    .i_ptr   (w_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) w_next = ctr_dWEN[w_arb_idx] ? WR : RD;
      end
      RD, WR: begin
        // dhit outranks both flush and timeout.
        if (dhit) begin
          w_hit  = 1'b1;
          w_next = IDLE;
        end else if (!ctr_dREN[r_dsel] && !ctr_dWEN[r_dsel]) begin
          w_next = IDLE;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= SW'(NPORT - 1);
      r_dsel  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (w_arb_valid) r_dsel <= w_arb_idx;
      end else if (w_next != IDLE) begin
        r_cnt <= r_cnt + TMO_W'(1);
      end
      if (w_hit || w_tmo) r_last <= r_dsel;
    end
  end

  // Outputs are masked by RST so an abandoned transaction never strobes.
  assign dmemREN   = (r_state == RD) && !RST;
  assign dmemWEN   = (r_state == WR) && !RST;
  assign dgrant    = (w_hit && !RST) ? (NPORT'(1) << r_dsel) : '0;
  assign dtmo      = w_tmo && !RST;
  assign dsel      = r_dsel;
  assign dbg_state = r_state;
  assign imemREN   = (IYIELD != 0) ? (ctr_iREN && (r_state == IDLE)) : ctr_iREN;

endmodule

// File: tb/tb_request_unit_arb.sv
// Directed bench for request_unit_arb: per-feature tasks plus a grant/timeout event scoreboard.
module tb_request_unit_arb;
  import cpu_types_pkg::*;

  localparam int NPORT = 2;
  localparam int SW    = 1;
  localparam int EW    = 1 + NPORT + SW;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ctr_iREN = 1'b0;
  logic [NPORT-1:0] ctr_dREN = '0;
  logic [NPORT-1:0] ctr_dWEN = '0;
  logic             ihit = 1'b0;
  logic             dhit = 1'b0;

  logic             imemREN, dmemREN, dmemWEN, dtmo;
  logic [SW-1:0]    dsel;
  logic [NPORT-1:0] dgrant;
  logic [1:0]       dbg_state;

  logic             ny_imemREN, ny_dmemREN, ny_dmemWEN, ny_dtmo;
  logic [SW-1:0]    ny_dsel;
  logic [NPORT-1:0] ny_dgrant;
  logic [1:0]       ny_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  always #5 CLK = ~CLK;

  request_unit_arb #(.NPORT(NPORT), .TMO_MAX(4), .IYIELD(1)) dut (
    .CLK(CLK), .RST(RST), .ctr_iREN(ctr_iREN), .ctr_dREN(ctr_dREN), .ctr_dWEN(ctr_dWEN),
    .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dsel(dsel), .dgrant(dgrant), .dtmo(dtmo), .dbg_state(dbg_state)
  );

  request_unit_arb #(.NPORT(NPORT), .TMO_MAX(255), .IYIELD(0)) dut_ny (
    .CLK(CLK), .RST(RST), .ctr_iREN(ctr_iREN), .ctr_dREN(ctr_dREN), .ctr_dWEN(ctr_dWEN),
    .ihit(ihit), .dhit(dhit), .imemREN(ny_imemREN), .dmemREN(ny_dmemREN), .dmemWEN(ny_dmemWEN),
    .dsel(ny_dsel), .dgrant(ny_dgrant), .dtmo(ny_dtmo), .dbg_state(ny_dbg_state)
  );

  function automatic logic [EW-1:0] gr(int p);
    return {1'b0, NPORT'(1) << p, SW'(p)};
  endfunction

  function automatic logic [EW-1:0] tm(int p);
    return {1'b1, {NPORT{1'b0}}, SW'(p)};
  endfunction

  // Scoreboard: every grant/timeout strobe must match the oldest expected event.
  always @(negedge CLK) begin
    if (RST === 1'b0 && (dgrant !== '0 || dtmo !== 1'b0)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected got {dtmo,dgrant,dsel}=%b want no event", {dtmo, dgrant, dsel});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({dtmo, dgrant, dsel} !== mon_exp) begin
          n_errors++;
          $display("FAIL sb_event got {dtmo,dgrant,dsel}=%b want %b", {dtmo, dgrant, dsel}, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    ihit = 1'($urandom_range(0, 1));
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    step();
    RST = 1'b1;
    ctr_dREN = '0;
    ctr_dWEN = '0;
    dhit = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    step();
    mid();
    n_checks++;
    if ({dmemREN, dmemWEN, dgrant, dtmo, dsel} !== '0 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL reset_during got ren=%b wen=%b grant=%b tmo=%b dsel=%0d st=%0d want all 0",
               dmemREN, dmemWEN, dgrant, dtmo, dsel, dbg_state);
    end
    step();
    RST = 1'b0;
    mid();
    n_checks++;
    if ({dmemREN, dmemWEN, dgrant, dtmo, dsel} !== '0 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL reset_after got ren=%b wen=%b grant=%b tmo=%b dsel=%0d st=%0d want all 0",
               dmemREN, dmemWEN, dgrant, dtmo, dsel, dbg_state);
    end
  endtask

  task automatic test_read_latency();
    step();
    ctr_dREN = 2'b01;
    mid();
    n_checks++;
    if (dbg_state !== IDLE || dmemREN !== 1'b0) begin
      n_errors++;
      $display("FAIL rdlat_t0 got st=%0d ren=%b want IDLE/0", dbg_state, dmemREN);
    end
    for (int c = 1; c <= 2; c++) begin
      step();
      mid();
      n_checks++;
      if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || dsel !== 1'b0 || dgrant !== 2'b00) begin
        n_errors++;
        $display("FAIL rdlat_t%0d got ren=%b wen=%b dsel=%0d grant=%b want 1/0/0/00", c, dmemREN, dmemWEN, dsel, dgrant);
      end
    end
    step();
    dhit = 1'b1;
    exp_q.push_back(gr(0));
    mid();
    n_checks++;
    if (dmemREN !== 1'b1 || dgrant !== 2'b01) begin
      n_errors++;
      $display("FAIL rdlat_t3 got ren=%b grant=%b want 1/01", dmemREN, dgrant);
    end
    step();
    dhit = 1'b0;
    ctr_dREN = '0;
    mid();
    n_checks++;
    if (dbg_state !== IDLE || dmemREN !== 1'b0 || dgrant !== 2'b00) begin
      n_errors++;
      $display("FAIL rdlat_t4 got st=%0d ren=%b grant=%b want IDLE/0/00", dbg_state, dmemREN, dgrant);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ctr_dWEN = 2'b11;
    dhit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      n_checks++;
      if (dbg_state !== IDLE || dmemWEN !== 1'b0 || dgrant !== 2'b00) begin
        n_errors++;
        $display("FAIL b2b_gap%0d got st=%0d wen=%b grant=%b want IDLE/0/00", k, dbg_state, dmemWEN, dgrant);
      end
      exp_q.push_back(gr(k % 2));
      step();
      mid();
      n_checks++;
      if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dsel !== SW'(k % 2)) begin
        n_errors++;
        $display("FAIL b2b_xfer%0d got wen=%b ren=%b dsel=%0d want 1/0/%0d", k, dmemWEN, dmemREN, dsel, k % 2);
      end
      step();
    end
    ctr_dWEN = '0;
    dhit = 1'b0;
    mid();
  endtask

  task automatic test_timeout();
    do_reset();
    ctr_dREN = 2'b10;
    mid();
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) begin
        ctr_dREN = 2'b11;
        exp_q.push_back(tm(1));
      end
      mid();
      n_checks++;
      if (dmemREN !== 1'b1 || dsel !== 1'b1 || dtmo !== (c == 4) || dgrant !== 2'b00) begin
        n_errors++;
        $display("FAIL tmo_rd%0d got ren=%b dsel=%0d tmo=%b grant=%b want 1/1/%0d/00",
                 c, dmemREN, dsel, dtmo, dgrant, (c == 4));
      end
    end
    step();
    mid();
    n_checks++;
    if (dbg_state !== IDLE || dtmo !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_idle got st=%0d tmo=%b want IDLE/0", dbg_state, dtmo);
    end
    step();
    dhit = 1'b1;
    exp_q.push_back(gr(0));
    mid();
    n_checks++;
    if (dmemREN !== 1'b1 || dsel !== 1'b0 || dgrant !== 2'b01) begin
      n_errors++;
      $display("FAIL tmo_next got ren=%b dsel=%0d grant=%b want 1/0/01", dmemREN, dsel, dgrant);
    end
    step();
    dhit = 1'b0;
    ctr_dREN = '0;
    mid();
  endtask

  task automatic test_flush();
    do_reset();
    ctr_dWEN = 2'b01;
    mid();
    step();
    mid();
    n_checks++;
    if (dmemWEN !== 1'b1 || dsel !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_wr got wen=%b dsel=%0d want 1/0", dmemWEN, dsel);
    end
    step();
    ctr_dWEN = '0;
    mid();
    n_checks++;
    if (dgrant !== 2'b00 || dtmo !== 1'b0 || dmemWEN !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_drop got grant=%b tmo=%b wen=%b want 00/0/1", dgrant, dtmo, dmemWEN);
    end
    step();
    mid();
    n_checks++;
    if (dbg_state !== IDLE || dmemWEN !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_idle got st=%0d wen=%b want IDLE/0", dbg_state, dmemWEN);
    end
    step();
    ctr_dWEN = 2'b01;
    mid();
    step();
    mid();
    n_checks++;
    if (dmemWEN !== 1'b1 || dsel !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_retry got wen=%b dsel=%0d want 1/0", dmemWEN, dsel);
    end
    step();
    ctr_dWEN = '0;
    dhit = 1'b1;
    exp_q.push_back(gr(0));
    mid();
    n_checks++;
    if (dgrant !== 2'b01 || dtmo !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_hit got grant=%b tmo=%b want 01/0", dgrant, dtmo);
    end
    step();
    dhit = 1'b0;
    mid();
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL flush_end got st=%0d want IDLE", dbg_state);
    end
  endtask

  task automatic test_iyield();
    step();
    ctr_iREN = 1'b1;
    ctr_dREN = 2'b01;
    mid();
    n_checks++;
    if (imemREN !== 1'b1 || ny_imemREN !== 1'b1) begin
      n_errors++;
      $display("FAIL iy_t0 got imem=%b ny_imem=%b want 1/1", imemREN, ny_imemREN);
    end
    step();
    mid();
    n_checks++;
    if (imemREN !== 1'b0 || ny_imemREN !== 1'b1 || dmemREN !== 1'b1) begin
      n_errors++;
      $display("FAIL iy_t1 got imem=%b ny_imem=%b ren=%b want 0/1/1", imemREN, ny_imemREN, dmemREN);
    end
    step();
    dhit = 1'b1;
    exp_q.push_back(gr(0));
    mid();
    n_checks++;
    if (imemREN !== 1'b0 || ny_imemREN !== 1'b1 || dgrant !== 2'b01) begin
      n_errors++;
      $display("FAIL iy_t2 got imem=%b ny_imem=%b grant=%b want 0/1/01", imemREN, ny_imemREN, dgrant);
    end
    step();
    dhit = 1'b0;
    ctr_dREN = '0;
    mid();
    n_checks++;
    if (imemREN !== 1'b1 || ny_imemREN !== 1'b1) begin
      n_errors++;
      $display("FAIL iy_t3 got imem=%b ny_imem=%b want 1/1", imemREN, ny_imemREN);
    end
  endtask

  task automatic test_reset_mid();
    step();
    ctr_dREN = 2'b10;
    mid();
    step();
    mid();
    n_checks++;
    if (dmemREN !== 1'b1 || dsel !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_rd got ren=%b dsel=%0d want 1/1", dmemREN, dsel);
    end
    step();
    RST = 1'b1;
    ctr_dREN = '0;
    mid();
    n_checks++;
    if ({dmemREN, dmemWEN, dgrant, dtmo} !== '0) begin
      n_errors++;
      $display("FAIL rstmid_during got ren=%b wen=%b grant=%b tmo=%b want 0", dmemREN, dmemWEN, dgrant, dtmo);
    end
    step();
    RST = 1'b0;
    ctr_dREN = 2'b11;
    mid();
    n_checks++;
    if ({dmemREN, dmemWEN, dgrant, dtmo, dsel} !== '0 || dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL rstmid_after got ren=%b wen=%b grant=%b tmo=%b dsel=%0d st=%0d want 0/IDLE",
               dmemREN, dmemWEN, dgrant, dtmo, dsel, dbg_state);
    end
    step();
    dhit = 1'b1;
    exp_q.push_back(gr(0));
    mid();
    n_checks++;
    if (dmemREN !== 1'b1 || dsel !== 1'b0 || dgrant !== 2'b01) begin
      n_errors++;
      $display("FAIL rstmid_first got ren=%b dsel=%0d grant=%b want 1/0/01", dmemREN, dsel, dgrant);
    end
    step();
    dhit = 1'b0;
    ctr_dREN = '0;
    mid();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_iyield();
    test_reset_mid();
    step();
    mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain got %0d pending events want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
